spi_arb: RTL and testbench
==========================

Name: spi_arb

Overview:
- Shares one 16-bit SPI master between two requesters: port 0 is the inertial interface and port 1 is the A2D interface.
- Captures single-cycle write requests, arbitrates round-robin between them, and issues one transaction at a time to the master.
- Steers the master's active-low slave select to the correct device and returns the read data and a completion pulse to the requester that owns the transaction.
- Sits between Digital_core/A2D_Intf and a single SPI_mstr16 instance at the Segway top level.

Parameters:
- TMO_W, 16, width of the per-transaction watchdog counter.
- TMO_CYC, 16'hFFFF, cycles allowed between mst_wrt and mst_done before the transaction is aborted.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wrt0  in  1  port-0 (inertial) transaction request pulse
- cmd0  in  16  port-0 command, sampled when wrt0=1
- done0  out  1  port-0 completion pulse
- rd_data0  out  16  port-0 read data, valid from done0 until the next port-0 completion
- wrt1  in  1  port-1 (A2D) transaction request pulse
- cmd1  in  16  port-1 command, sampled when wrt1=1
- done1  out  1  port-1 completion pulse
- rd_data1  out  16  port-1 read data
- mst_wrt  out  1  start pulse to the SPI master
- mst_cmd  out  16  command to the SPI master
- mst_done  in  1  SPI master completion pulse
- mst_rd_data  in  16  SPI master read data
- mst_SS_n  in  1  SPI master slave select, active low
- SS0_n  out  1  inertial slave select
- SS1_n  out  1  A2D slave select
- err  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset values:
  - done0, done1, mst_wrt, err = 0.
  - SS0_n, SS1_n = 1.
  - rd_data0, rd_data1, mst_cmd = 0.
  - Pending flags = 0; last_gnt = 1, so port 0 wins the first tie.
  - State = IDLE.
- Request capture:
  - wrtX=1 with pendX=0 and port X not in service: pendX<=1, cmdX latched into pcmdX.
  - wrtX while pendX=1 or port X is in service: the request is dropped, pcmdX is unchanged, and err<=1.
  - wrt0 and wrt1 in the same cycle: both are captured.
- States: IDLE, ISSUE, BUSY.
- IDLE:
  - If any pend flag is set, choose gnt. When both are set, gnt = ~last_gnt; otherwise gnt is the single pending port.
  - Load mst_cmd<=pcmd[gnt], clear pend[gnt], set last_gnt<=gnt, go to ISSUE.
  - A request captured at clock edge N is first visible to IDLE in the cycle after edge N.
- ISSUE:
  - mst_wrt=1 for exactly one cycle (registered).
  - Watchdog cleared. Go to BUSY.
- BUSY:
  - Watchdog increments each cycle.
  - On mst_done:
    - rd_data[gnt]<=mst_rd_data.
    - done[gnt]=1 for one cycle in the following cycle.
    - Go to IDLE.
  - On watchdog == TMO_CYC-1 without mst_done:
    - err<=1, done[gnt] pulses, rd_data[gnt]<=16'hFFFF.
    - Go to IDLE.
- Latency, uncontended, from IDLE:
  - wrtX at edge N -> mst_wrt high in cycle N+2.
  - doneX is high in the cycle after mst_done.
- SS steering (combinational):
  - SS0_n = mst_SS_n | gnt.
  - SS1_n = mst_SS_n | ~gnt.
  - In IDLE, both stay 1 regardless of mst_SS_n.
- Back-to-back: leaving BUSY goes to IDLE, so a pending request from the other port issues 2 cycles after mst_done.
- Fairness: with both ports requesting continuously, grants strictly alternate 0,1,0,1.
- Ignored inputs:
  - mst_done in IDLE or ISSUE is ignored.
  - A new wrtX during BUSY for the non-granted port is captured normally.
- Reset asserted mid-transaction: the arbiter returns to IDLE with all pending flags and outputs at reset values. The SPI master is reset by the same rst_n.

Decomposition:
- spi_arb_pkg holds:
  - state enum {IDLE, ISSUE, BUSY};
  - port index constants INERT=0, A2D=1;
  - TMO_RD_DATA = 16'hFFFF.
- One natural sub-module: spi_arb_req, instantiated twice. It holds the per-port pend flag, pcmd register and drop-error detection; the arbiter FSM and watchdog stay in spi_arb.

Test Plan:
- wrt0 with cmd0=16'hA5C3 in IDLE -> mst_wrt at +2 cycles with mst_cmd=16'hA5C3; SS0_n follows mst_SS_n and SS1_n stays 1; mst_done with mst_rd_data=16'h1234 -> done0 for 1 cycle, rd_data0=16'h1234, done1 never asserted.
- wrt0 (16'h0001) and wrt1 (16'h0002) in the same cycle after reset -> port 0 is served first, then port 1 is issued 2 cycles after the first mst_done; rd_data routed correctly to each port.
- Both ports re-request on every doneX for 6 transactions -> grant order is 0,1,0,1,0,1 and no err.
- wrt1 issued while port 1 is in BUSY -> request dropped, err=1, exactly one done1 observed.
- TMO_CYC=16, mst_done withheld -> at 16 cycles after mst_wrt: done[gnt] pulses, rd_data=16'hFFFF, err=1; the next request proceeds normally.
- rst_n dropped during BUSY with port 1 pending -> all outputs at reset values, pend cleared, and no mst_wrt after rst_n rises until a new wrt arrives.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared constants for the two-port SPI arbiter: FSM encoding, port indices
// and the read data returned when a transaction is aborted.
package spi_arb_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] BUSY  = 2'd2;

  localparam logic INERT = 1'b0;
  localparam logic A2D   = 1'b1;

  localparam logic [15:0] TMO_RD_DATA = 16'hFFFF;

  // On a tie the port that did not win last time goes next.
  function automatic logic pick_gnt(input logic p0, input logic p1, input logic last);
    return (p0 & p1) ? ~last : p1;
  endfunction

endpackage

// File: rtl/spi_arb_if.sv
// Bundle of requester-side and SPI-master-side signals around the arbiter.
// slave is the arbiter's view, master is the surrounding system's view.
interface spi_arb_if;

  logic        wrt0;
  logic [15:0] cmd0;
  logic        done0;
  logic [15:0] rd_data0;
  logic        wrt1;
  logic [15:0] cmd1;
  logic        done1;
  logic [15:0] rd_data1;
  logic        mst_wrt;
  logic [15:0] mst_cmd;
  logic        mst_done;
  logic [15:0] mst_rd_data;
  logic        mst_SS_n;
  logic        SS0_n;
  logic        SS1_n;
  logic        err;

  modport slave (
    input  wrt0, cmd0, wrt1, cmd1, mst_done, mst_rd_data, mst_SS_n,
    output done0, rd_data0, done1, rd_data1, mst_wrt, mst_cmd, SS0_n, SS1_n, err
  );

  modport master (
    output wrt0, cmd0, wrt1, cmd1, mst_done, mst_rd_data, mst_SS_n,
    input  done0, rd_data0, done1, rd_data1, mst_wrt, mst_cmd, SS0_n, SS1_n, err
  );

endinterface

// File: rtl/spi_arb_req.sv
// Per-port request holder: one pending command slot, plus detection of
// requests that arrive while the slot is full or the port is being served.
module spi_arb_req (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] cmd,
  input  logic        in_service,
  input  logic        take,
  output logic        pend,
  output logic [15:0] pcmd,
  output logic        drop
);

  assign drop = wrt & (pend | in_service);

  // take only happens while pend is set, so it can never collide with a capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
      pcmd <= 16'h0000;
    end else if (wrt && !drop) begin
      pend <= 1'b1;
      pcmd <= cmd;
    end else if (take) begin
      pend <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_arb.sv
// Round-robin sharing of one 16-bit SPI master between the inertial (port 0)
// and A2D (port 1) interfaces, with a per-transaction watchdog.
module spi_arb
  import spi_arb_pkg::*;
#(
  parameter int               TMO_W   = 16,
  parameter logic [TMO_W-1:0] TMO_CYC = 16'hFFFF
) (
  input logic       clk,
  input logic       rst_n,
  spi_arb_if.slave  bus
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_CYC - 1'b1;

  logic [1:0]       state;
  logic             gnt;
  logic             last_gnt;
  logic [TMO_W-1:0] wdog;

  logic        pend0, pend1;
  logic [15:0] pcmd0, pcmd1;
  logic        drop0, drop1;
  logic        next_gnt;
  logic        grant_now;
  logic        finish;
  logic [15:0] ret_data;

  assign next_gnt  = pick_gnt(pend0, pend1, last_gnt);
  assign grant_now = (state == IDLE) && (pend0 || pend1);
  assign finish    = (state == BUSY) && (bus.mst_done || (wdog == TMO_LAST));
  assign ret_data  = bus.mst_done ? bus.mst_rd_data : TMO_RD_DATA;

  spi_arb_req u_req0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .wrt        (bus.wrt0),
    .cmd        (bus.cmd0),
    .in_service ((state != IDLE) && (gnt == INERT)),
    .take       (grant_now && (next_gnt == INERT)),
    .pend       (pend0),
    .pcmd       (pcmd0),
    .drop       (drop0)
  );

  spi_arb_req u_req1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .wrt        (bus.wrt1),
    .cmd        (bus.cmd1),
    .in_service ((state != IDLE) && (gnt == A2D)),
    .take       (grant_now && (next_gnt == A2D)),
    .pend       (pend1),
    .pcmd       (pcmd1),
    .drop       (drop1)
  );

  // Slave selects are only steered while a transaction owns the master.
  assign bus.SS0_n = (state == IDLE) | bus.mst_SS_n | gnt;
  assign bus.SS1_n = (state == IDLE) | bus.mst_SS_n | ~gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      gnt          <= INERT;
      last_gnt     <= A2D;
      wdog         <= '0;
      bus.mst_wrt  <= 1'b0;
      bus.mst_cmd  <= 16'h0000;
      bus.done0    <= 1'b0;
      bus.done1    <= 1'b0;
      bus.rd_data0 <= 16'h0000;
      bus.rd_data1 <= 16'h0000;
      bus.err      <= 1'b0;
    end else begin
      bus.mst_wrt <= 1'b0;
      bus.done0   <= 1'b0;
      bus.done1   <= 1'b0;
      if (drop0 || drop1) bus.err <= 1'b1;

      case (state)
        IDLE: begin
          if (grant_now) begin
            gnt         <= next_gnt;
            last_gnt    <= next_gnt;
            bus.mst_cmd <= next_gnt ? pcmd1 : pcmd0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          bus.mst_wrt <= 1'b1;
          wdog        <= '0;
          state       <= BUSY;
        end
        BUSY: begin
          // mst_done wins over a watchdog expiry landing in the same cycle.
          if (finish) begin
            if (!bus.mst_done) bus.err <= 1'b1;
            if (gnt == A2D) begin
              bus.rd_data1 <= ret_data;
              bus.done1    <= 1'b1;
            end else begin
              bus.rd_data0 <= ret_data;
              bus.done0    <= 1'b1;
            end
            state <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arb.sv
// Self-checking bench for spi_arb: directed scenarios plus randomized request
// patterns against a transaction-level round-robin model.
module tb_spi_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  spi_arb_if bus ();

  spi_arb #(.TMO_W(16), .TMO_CYC(16'd16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: which ports hold a request, their commands, and who was served last.
  logic        mpend [2];
  logic [15:0] mcmd  [2];
  int          mlast;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pickModel();
    if (mpend[0] && mpend[1]) return (mlast == 1) ? 0 : 1;
    else if (mpend[0]) return 0;
    else return 1;
  endfunction

  task automatic applyReset();
    rst_n = 1'b0;
    bus.wrt0 = 1'b0; bus.cmd0 = 16'h0; bus.wrt1 = 1'b0; bus.cmd1 = 16'h0;
    bus.mst_done = 1'b0; bus.mst_rd_data = 16'h0; bus.mst_SS_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    mpend[0] = 1'b0; mpend[1] = 1'b0;
    mlast = 1;
  endtask

  // Drives request pulses for one cycle; returns in the cycle after capture.
  task automatic applyStimulus(input logic w0, input logic [15:0] c0,
                               input logic w1, input logic [15:0] c1);
    bus.wrt0 = w0; bus.cmd0 = c0;
    bus.wrt1 = w1; bus.cmd1 = c1;
    step();
    bus.wrt0 = 1'b0; bus.wrt1 = 1'b0;
    if (w0) begin mpend[0] = 1'b1; mcmd[0] = c0; end
    if (w1) begin mpend[1] = 1'b1; mcmd[1] = c1; end
  endtask

  task automatic waitMstWrt(output int cycles);
    cycles = 0;
    while (bus.mst_wrt !== 1'b1 && cycles < 100) begin
      step();
      cycles++;
    end
    if (bus.mst_wrt !== 1'b1) checkOutput("mst_wrt_timeout", 32'd0, 32'd1);
  endtask

  // Plays the SPI master for one transaction owned by the given port.
  task automatic doTxn(input int port, input int delay, input logic [15:0] rd);
    int c;
    waitMstWrt(c);
    checkOutput("mst_cmd", bus.mst_cmd, mcmd[port]);
    bus.mst_SS_n = 1'b0;
    #1;
    checkOutput("ss0_n_busy", bus.SS0_n, (port == 0) ? 0 : 1);
    checkOutput("ss1_n_busy", bus.SS1_n, (port == 1) ? 0 : 1);
    repeat (delay) step();
    bus.mst_done = 1'b1; bus.mst_rd_data = rd;
    step();
    bus.mst_done = 1'b0; bus.mst_SS_n = 1'b1;
    checkOutput("done_owner", (port == 0) ? bus.done0 : bus.done1, 1);
    checkOutput("done_other", (port == 0) ? bus.done1 : bus.done0, 0);
    checkOutput("rd_data", (port == 0) ? bus.rd_data0 : bus.rd_data1, rd);
    step();
    checkOutput("done_width", bus.done0 | bus.done1, 0);
    mpend[port] = 1'b0;
    mlast = port;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] bench did not finish");
  end

  initial begin
    int c, n_done, n_wrt, p, m;
    logic [15:0] c0, c1, rd;

    // Reset state
    applyReset();
    checkOutput("rst_mst_wrt", bus.mst_wrt, 0);
    checkOutput("rst_done0", bus.done0, 0);
    checkOutput("rst_done1", bus.done1, 0);
    checkOutput("rst_err", bus.err, 0);
    checkOutput("rst_mst_cmd", bus.mst_cmd, 0);
    checkOutput("rst_rd0", bus.rd_data0, 0);
    checkOutput("rst_rd1", bus.rd_data1, 0);
    bus.mst_SS_n = 1'b0;
    #1;
    checkOutput("idle_ss0_n", bus.SS0_n, 1);
    checkOutput("idle_ss1_n", bus.SS1_n, 1);
    bus.mst_SS_n = 1'b1;

    // Single uncontended port-0 transaction
    applyStimulus(1'b1, 16'hA5C3, 1'b0, 16'h0);
    waitMstWrt(c);
    checkOutput("lat_uncontended", c, 2);
    doTxn(0, 3, 16'h1234);

    // Simultaneous requests after reset: port 0 first, then port 1
    applyReset();
    applyStimulus(1'b1, 16'h0001, 1'b1, 16'h0002);
    p = pickModel();
    doTxn(p, 2, 16'hBEEF);
    waitMstWrt(c);
    checkOutput("b2b_gap", c, 1);
    doTxn(pickModel(), 5, 16'hCAFE);
    checkOutput("rd0_hold", bus.rd_data0, 16'hBEEF);
    checkOutput("rd1_final", bus.rd_data1, 16'hCAFE);

    // Continuous re-requests from both ports
    applyReset();
    c0 = 16'($urandom) & 16'h7FFF;
    c1 = 16'($urandom) | 16'h8000;
    applyStimulus(1'b1, c0, 1'b1, c1);
    for (int i = 0; i < 6; i++) begin
      p = pickModel();
      doTxn(p, $urandom_range(1, 8), 16'($urandom));
      if (i < 5) begin
        if (p == 0) applyStimulus(1'b1, 16'($urandom) & 16'h7FFF, 1'b0, 16'h0);
        else        applyStimulus(1'b0, 16'h0, 1'b1, 16'($urandom) | 16'h8000);
      end
    end
    checkOutput("fair_err", bus.err, 0);

    // Request from the port already in service is dropped
    applyReset();
    applyStimulus(1'b0, 16'h0, 1'b1, 16'h1111);
    waitMstWrt(c);
    checkOutput("drop_cmd", bus.mst_cmd, 16'h1111);
    bus.mst_SS_n = 1'b0;
    step();
    bus.wrt1 = 1'b1; bus.cmd1 = 16'h2222;
    step();
    bus.wrt1 = 1'b0;
    checkOutput("drop_err", bus.err, 1);
    bus.mst_done = 1'b1; bus.mst_rd_data = 16'h5A5A;
    step();
    bus.mst_done = 1'b0; bus.mst_SS_n = 1'b1;
    n_done = 0; n_wrt = 0;
    for (int i = 0; i < 12; i++) begin
      n_done += int'(bus.done1);
      n_wrt  += int'(bus.mst_wrt);
      step();
    end
    checkOutput("drop_done1_count", n_done, 1);
    checkOutput("drop_no_reissue", n_wrt, 0);
    checkOutput("drop_rd1", bus.rd_data1, 16'h5A5A);

    // Watchdog abort with mst_done withheld
    applyReset();
    applyStimulus(1'b1, 16'h0F0F, 1'b0, 16'h0);
    waitMstWrt(c);
    c = 0;
    while (bus.done0 !== 1'b1 && c < 40) begin
      step();
      c++;
    end
    checkOutput("tmo_latency", c, 16);
    checkOutput("tmo_rd0", bus.rd_data0, 16'hFFFF);
    checkOutput("tmo_err", bus.err, 1);
    checkOutput("tmo_done1", bus.done1, 0);
    mpend[0] = 1'b0; mlast = 0;
    step();
    applyStimulus(1'b0, 16'h0, 1'b1, 16'h3C3C);
    doTxn(1, 4, 16'h9876);

    // Reset in the middle of a transaction with port 1 pending
    applyReset();
    applyStimulus(1'b1, 16'h7777, 1'b0, 16'h0);
    waitMstWrt(c);
    bus.mst_SS_n = 1'b0;
    step();
    applyStimulus(1'b0, 16'h0, 1'b1, 16'h8888);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mrst_mst_wrt", bus.mst_wrt, 0);
    checkOutput("mrst_done", {bus.done0, bus.done1}, 0);
    checkOutput("mrst_err", bus.err, 0);
    checkOutput("mrst_ss", {bus.SS0_n, bus.SS1_n}, 2'b11);
    checkOutput("mrst_mst_cmd", bus.mst_cmd, 0);
    checkOutput("mrst_rd", {bus.rd_data0, bus.rd_data1}, 0);
    bus.mst_SS_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    mpend[0] = 1'b0; mpend[1] = 1'b0; mlast = 1;
    n_wrt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_wrt += int'(bus.mst_wrt);
    end
    checkOutput("mrst_no_wrt", n_wrt, 0);
    applyStimulus(1'b1, 16'h4242, 1'b0, 16'h0);
    doTxn(0, 2, 16'h0BAD);

    // Randomized request patterns against the model
    applyReset();
    for (int it = 0; it < 20; it++) begin
      m  = $urandom_range(1, 3);
      c0 = 16'($urandom);
      c1 = 16'($urandom);
      applyStimulus(m[0], c0, m[1], c1);
      while (mpend[0] || mpend[1]) begin
        p  = pickModel();
        rd = 16'($urandom);
        doTxn(p, $urandom_range(1, 8), rd);
      end
      repeat ($urandom_range(0, 3)) step();
    end
    checkOutput("rand_err", bus.err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
